sra_iterative: RTL
==================

Name: sra_iterative

Overview:
- Multicycle logical/arithmetic right shifter for the CPU shift path; the right-direction counterpart of the combinational left-shift stages.
- Captures an operand and a 5-bit shift amount on a start pulse.
- Applies one binary-weighted shift stage per clock (16, 8, 4, 2, 1), then presents the result with a one-cycle ready pulse.
- Sits beside the ALU; the execute-stage controller stalls on `busy`.

Parameters:
- WIDTH, 32, data width in bits. Must equal 2^SHAMT_BITS.
- SHAMT_BITS, 5, shift-amount width. Also the number of shift stages.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_start  input  1  start request; sampled only in IDLE.
- ctrl_arith  input  1  1 = arithmetic shift (sign fill); 0 = logical shift (zero fill).
- data_operandA  input  WIDTH  operand to shift.
- ctrl_shiftamt  input  SHAMT_BITS  shift amount, 0..WIDTH-1.
- data_result  output  WIDTH  shifted result; holds its value until the next completion.
- data_resultRDY  output  1  one-cycle pulse: data_result is valid.
- busy  output  1  high while an operation is in flight (SHIFT state).

Behaviour:
- Reset (synchronous, active-high): state=IDLE; data_result=0; data_resultRDY=0; busy=0; internal operand, shift-amount, stage-index and arith registers = 0.
- States:
  - IDLE: busy=0. If ctrl_start=1 at edge k: latch data_operandA, ctrl_shiftamt and ctrl_arith; set stage index = SHAMT_BITS-1; go to SHIFT.
  - SHIFT: busy=1. Each edge, if latched shamt bit[idx]=1, shift the working value right by 2^idx. Fill is working-value bit WIDTH-1 when arith=1, else 0. Then decrement idx. The edge that processes idx=0 writes data_result, sets data_resultRDY=1, and goes to DONE.
  - DONE: one cycle only. data_resultRDY=1, busy=0. Next edge: data_resultRDY=0, go to IDLE.
- Latency without the optional feature: start sampled at edge k → data_result valid and data_resultRDY=1 after edge k+5 for every shift amount (fixed 5 cycles).
- Back-to-back operation: a new start is accepted in IDLE only. The earliest next capture is edge k+7.
- ctrl_start while in SHIFT or DONE is ignored. No queuing. Operand and amount input changes are ignored after capture.
- shamt=0: result equals the operand, with full 5-cycle latency.
- Sign fill uses the captured operand's MSB. Because arithmetic shift preserves the MSB, the sign is consistent across stages.
- data_result changes only on the completion edge or on reset. It is never partially updated while in SHIFT.
- Reset asserted mid-operation (any state) aborts it:
  - outputs return to reset values on that edge;
  - no data_resultRDY pulse is produced for the aborted operation;
  - a start in the first cycle after reset deasserts is accepted.
- ctrl_start and reset high at the same edge: reset wins.

Optional Feature:
- Macro: SRA_EARLY_EXIT_EN.
- Defined: SHIFT skips trailing zero stages.
  - Let p be the position of the lowest set bit of the captured shamt.
  - Completion happens on the edge that processes idx=p, i.e. data_resultRDY after edge k+(5-p).
  - shamt=0: SHIFT is bypassed; data_result=operand and data_resultRDY=1 after edge k+1.
  - DONE and IDLE behaviour are unchanged.
- Undefined: fixed 5-cycle latency as described above; no early-exit logic is synthesized.

Test Plan:
1. A=0x80000000, shamt=16, arith=1, start at edge k → data_resultRDY=1 after edge k+5 for exactly one cycle; data_result=0xFFFF8000; busy high after edges k+1..k+4.
2. Same operand, arith=0 → data_result=0x00008000; then A=0x12345678, shamt=0 → data_result=0x12345678 after edge k+5.
3. A=0xF000000F, shamt=31, arith=1 → 0xFFFFFFFF; repeat with arith=0 → 0x00000001; data_result holds its value between operations.
4. Start accepted with A=0x7FFFFFFF, shamt=4; ctrl_start pulsed again at k+2 with A=0x1 → only one ready pulse, data_result=0x07FFFFFF; busy=0 in DONE.
5. Start with A=0x80000000, shamt=1, arith=1; reset at edge k+2 → data_result=0, ready=0, busy=0, no pulse later; a new start with A=0x100, shamt=8, arith=0 → 0x00000001 after 5 cycles.
6. With SRA_EARLY_EXIT_EN: shamt=4 (p=2), A=0xFFFFFF00, arith=1 → ready after edge k+3, result 0xFFFFFFF0; shamt=0 → ready after edge k+1, result=A; shamt=1 → ready after edge k+5.

Source files
------------

// File: rtl/sra_iterative_if.sv
// Bus bundle for the iterative right shifter: the start/operand side and the result/status side.
interface sra_iterative_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHAMT_BITS = 5
);
    logic                  ctrl_start;
    logic                  ctrl_arith;
    logic [WIDTH-1:0]      data_operandA;
    logic [SHAMT_BITS-1:0] ctrl_shiftamt;
    logic [WIDTH-1:0]      data_result;
    logic                  data_resultRDY;
    logic                  busy;

    // Requester side (execute-stage controller)
    modport master (
        output ctrl_start, ctrl_arith, data_operandA, ctrl_shiftamt,
        input  data_result, data_resultRDY, busy
    );

    // Shifter side
    modport slave (
        input  ctrl_start, ctrl_arith, data_operandA, ctrl_shiftamt,
        output data_result, data_resultRDY, busy
    );
endinterface

// File: rtl/sra_iterative.sv
// Multicycle logical/arithmetic right shifter: one binary-weighted stage per clock
// (2^(SHAMT_BITS-1) down to 1), result presented with a one-cycle ready pulse.
// Optional macro SRA_EARLY_EXIT_EN: finish at the lowest set shift-amount bit and
// bypass the shift stages entirely for a zero shift amount.
module sra_iterative #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHAMT_BITS = 5
) (
    input  logic          clock,
    input  logic          reset,
    sra_iterative_if.slave bus
);
    localparam int unsigned IDX_W = (SHAMT_BITS > 1) ? $clog2(SHAMT_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e                state_q;
    logic [WIDTH-1:0]      work_q;
    logic [SHAMT_BITS-1:0] amt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  arith_q;
    logic [WIDTH-1:0]      result_q;
    logic                  rdy_q;
    logic                  busy_q;

    logic [SHAMT_BITS-1:0] stage_amt;
    logic [WIDTH-1:0]      stage_d;
    logic                  last_c;

    assign bus.data_result    = result_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

    // Current stage: conditionally shift the working value by 2^idx with sign or zero fill
    always_comb begin
        stage_amt = SHAMT_BITS'(1) << idx_q;
        stage_d   = work_q;
        if (amt_q[idx_q]) begin
            if (arith_q) begin
                stage_d = $unsigned($signed(work_q) >>> stage_amt);
            end else begin
                stage_d = work_q >> stage_amt;
            end
        end
    end

    // Decide whether the stage being processed is the final one
`ifdef SRA_EARLY_EXIT_EN
    always_comb begin
        last_c = ((amt_q & (stage_amt - SHAMT_BITS'(1))) == '0);
    end
`else
    always_comb begin
        last_c = (idx_q == '0);
    end
`endif

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            amt_q    <= '0;
            idx_q    <= '0;
            arith_q  <= 1'b0;
            result_q <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rdy_q  <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.ctrl_start) begin
                        work_q  <= bus.data_operandA;
                        amt_q   <= bus.ctrl_shiftamt;
                        arith_q <= bus.ctrl_arith;
                        idx_q   <= IDX_W'(SHAMT_BITS - 1);
`ifdef SRA_EARLY_EXIT_EN
                        if (bus.ctrl_shiftamt == '0) begin
                            result_q <= bus.data_operandA;
                            rdy_q    <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= ST_SHIFT;
                        end
`else
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
`endif
                    end
                end
                ST_SHIFT: begin
                    work_q <= stage_d;
                    idx_q  <= idx_q - IDX_W'(1);
                    if (last_c) begin
                        result_q <= stage_d;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
